// File: rtl/alu_adder_sched.sv
// Shares one 16-bit adder between the EX-stage ALU (port 0) and the address/branch
// calculator (port 1): arbitrate, drive the adder for one cycle, return result and flags.
module alu_adder_sched #(
    parameter int TAG_W      = 2,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [31:0]          req_a,
    input  logic [31:0]          req_b,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [15:0]          rsp_data,
    output logic [2:0]           rsp_flags,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [15:0]          add_a,
    output logic [15:0]          add_b,
    output logic                 add_sub,
    output logic                 add_sat,
    output logic                 add_red,
    input  logic [15:0]          add_s,
    input  logic                 add_ovfl
);

    localparam int DATA_W = 16;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_PADDSB = 2'b10;
    localparam logic [1:0] OP_RED    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          gnt;
    logic                hs;
    logic                hs_port;
    logic                last_gnt;

    logic [1:0]          op_p0;
    logic [DATA_W-1:0]   a_p0;
    logic [DATA_W-1:0]   b_p0;
    logic [TAG_W-1:0]    tag_p0;
    logic                port_p0;

    // {Z,V,N}; overflow is only meaningful for plain ADD/SUB.
    function automatic logic [2:0] calc_flags(input logic [DATA_W-1:0] s,
                                              input logic              ovfl,
                                              input logic [1:0]        op);
        logic v;
        v = ovfl & ((op == OP_ADD) | (op == OP_SUB));
        return {(s == '0), v, s[DATA_W-1]};
    endfunction

    // Tie goes to port 0 (fixed) or to the port not granted last (round-robin).
    always_comb begin
        gnt = 2'b00;
        if (req_valid == 2'b11)
            gnt = (FIXED_PRIO || last_gnt) ? 2'b01 : 2'b10;
        else
            gnt = req_valid;
    end

    assign hs      = (state == IDLE) && (gnt != 2'b00);
    assign hs_port = gnt[1];

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                req_ready = gnt;
                if (gnt != 2'b00)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready[port_p0]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs)
                last_gnt <= hs_port;
        end
    end

    // Stage p0: accepted operation held for EXEC and RESP
    always_ff @(posedge clk) begin
        if (hs) begin
            op_p0   <= hs_port ? req_op[3:2]             : req_op[1:0];
            a_p0    <= hs_port ? req_a[31:16]            : req_a[15:0];
            b_p0    <= hs_port ? req_b[31:16]            : req_b[15:0];
            tag_p0  <= hs_port ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
            port_p0 <= hs_port;
        end
    end

    // Adder inputs are held at zero except during the single EXEC cycle.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        add_sat = 1'b0;
        add_red = 1'b0;
        if (state == EXEC) begin
            add_a = a_p0;
            add_b = b_p0;
            case (op_p0)
                OP_SUB: begin
                    add_b   = ~b_p0;
                    add_sub = 1'b1;
                end
                OP_PADDSB: add_sat = 1'b1;
                OP_RED:    add_red = 1'b1;
                default:   ;
            endcase
        end
    end

    // Stage p1: adder result captured at the end of EXEC, held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_tag   <= '0;
        end else if (state == EXEC) begin
            rsp_data  <= add_s;
            rsp_flags <= calc_flags(add_s, add_ovfl, op_p0);
            rsp_tag   <= tag_p0;
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (state == RESP)
            rsp_valid = port_p0 ? 2'b10 : 2'b01;
    end

endmodule

// File: tb/tb_alu_adder_sched.sv
// Directed bench for alu_adder_sched: round-robin and fixed-priority instances share all
// inputs; a behavioural adder closes the loop on each.
module tb_alu_adder_sched;
    localparam int TAG_W = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         req_valid;
    logic [3:0]         req_op;
    logic [31:0]        req_a, req_b;
    logic [2*TAG_W-1:0] req_tag;
    logic [1:0]         rsp_ready;

    logic [1:0]         req_ready, rsp_valid;
    logic [15:0]        rsp_data, add_a, add_b, add_s;
    logic [2:0]         rsp_flags;
    logic [TAG_W-1:0]   rsp_tag;
    logic               add_sub, add_sat, add_red, add_ovfl;

    logic [1:0]         f_req_ready, f_rsp_valid;
    logic [15:0]        f_rsp_data, f_add_a, f_add_b, f_add_s;
    logic [2:0]         f_rsp_flags;
    logic [TAG_W-1:0]   f_rsp_tag;
    logic               f_add_sub, f_add_sat, f_add_red, f_add_ovfl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural adder: RED -> xor, PADDSB -> plain sum; both raise ovfl so V masking is visible.
    function automatic logic [16:0] adder(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic sat, input logic red);
        logic [15:0] s;
        logic        v;
        if (red) return {1'b1, a ^ b};
        s = a + b;
        if (sat) return {1'b1, s};
        s = a + b + {15'b0, sub};
        v = (a[15] == b[15]) && (s[15] != a[15]);
        return {v, s};
    endfunction

    always_comb {add_ovfl, add_s}     = adder(add_a, add_b, add_sub, add_sat, add_red);
    always_comb {f_add_ovfl, f_add_s} = adder(f_add_a, f_add_b, f_add_sub, f_add_sat, f_add_red);

    alu_adder_sched #(.TAG_W(TAG_W), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_sat(add_sat),
        .add_red(add_red), .add_s(add_s), .add_ovfl(add_ovfl)
    );

    alu_adder_sched #(.TAG_W(TAG_W), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(f_req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(f_rsp_data),
        .rsp_flags(f_rsp_flags), .rsp_tag(f_rsp_tag),
        .add_a(f_add_a), .add_b(f_add_b), .add_sub(f_add_sub), .add_sat(f_add_sat),
        .add_red(f_add_red), .add_s(f_add_s), .add_ovfl(f_add_ovfl)
    );

    typedef struct {
        int          port;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  tag;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [2:0]  ectl;    // {sub,sat,red}
        logic [15:0] edata;
        logic [2:0]  eflags;  // {Z,V,N}
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] tag);
        req_op[p*2 +: 2]         = op;
        req_a[p*16 +: 16]        = a;
        req_b[p*16 +: 16]        = b;
        req_tag[p*TAG_W +: TAG_W] = tag;
        req_valid[p]             = 1'b1;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [1:0]  oh;
        v  = vecs[i];
        oh = (v.port == 1) ? 2'b10 : 2'b01;
        set_req(v.port, v.op, v.a, v.b, v.tag);
        #1;
        chk($sformatf("v%0d req_ready idle", i), req_ready, oh);
        tick();
        req_valid = 2'b00;
        chk($sformatf("v%0d add_a", i), add_a, v.ea);
        chk($sformatf("v%0d add_b", i), add_b, v.eb);
        chk($sformatf("v%0d add_ctl", i), {add_sub, add_sat, add_red}, v.ectl);
        chk($sformatf("v%0d req_ready exec", i), req_ready, 2'b00);
        chk($sformatf("v%0d rsp_valid exec", i), rsp_valid, 2'b00);
        tick();
        chk($sformatf("v%0d rsp_valid", i), rsp_valid, oh);
        chk($sformatf("v%0d rsp_data", i), rsp_data, v.edata);
        chk($sformatf("v%0d rsp_flags", i), rsp_flags, v.eflags);
        chk($sformatf("v%0d rsp_tag", i), rsp_tag, v.tag);
        chk($sformatf("v%0d add_a resp", i), add_a, 16'h0);
        rsp_ready = oh;
        tick();
        rsp_ready = 2'b00;
        chk($sformatf("v%0d rsp_valid after", i), rsp_valid, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_rr[3];

        req_op  = '0;
        req_a   = '0;
        req_b   = '0;
        req_tag = '0;

        vecs[0] = '{0, 2'b00, 16'h7000, 16'h2000, 2'd1, 16'h7000, 16'h2000, 3'b000, 16'h9000, 3'b011};
        vecs[1] = '{1, 2'b01, 16'h0005, 16'h0003, 2'd2, 16'h0005, 16'hFFFC, 3'b100, 16'h0002, 3'b000};
        vecs[2] = '{0, 2'b11, 16'h1234, 16'h1111, 2'd3, 16'h1234, 16'h1111, 3'b001, 16'h0325, 3'b000};
        vecs[3] = '{1, 2'b10, 16'hF000, 16'h0100, 2'd0, 16'hF000, 16'h0100, 3'b010, 16'hF100, 3'b001};
        vecs[4] = '{0, 2'b01, 16'h1234, 16'h1234, 2'd2, 16'h1234, 16'hEDCB, 3'b100, 16'h0000, 3'b100};
        vecs[5] = '{1, 2'b01, 16'h8000, 16'h0001, 2'd1, 16'h8000, 16'hFFFE, 3'b100, 16'h7FFF, 3'b010};
        vecs[6] = '{1, 2'b00, 16'hFFFF, 16'h0001, 2'd3, 16'hFFFF, 16'h0001, 3'b000, 16'h0000, 3'b100};

        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rst_n     = 1'b0;
        #1;
        chk("reset req_ready", req_ready, 2'b00);
        chk("reset rsp_valid", rsp_valid, 2'b00);
        chk("reset rsp_data", rsp_data, 16'h0);
        chk("reset rsp_flags", rsp_flags, 3'b000);
        chk("reset rsp_tag", rsp_tag, 2'd0);
        chk("reset add_bus", {add_a, add_b, add_sub, add_sat, add_red}, 35'h0);
        do_reset();

        for (int i = 0; i < 7; i++)
            run_vec(i);

        // Contention: round-robin alternates starting at port 1; fixed priority keeps port 0.
        do_reset();
        exp_rr[0] = 2'b10;
        exp_rr[1] = 2'b01;
        exp_rr[2] = 2'b10;
        set_req(0, 2'b00, 16'h0001, 16'h0001, 2'd1);
        set_req(1, 2'b00, 16'h0002, 16'h0002, 2'd2);
        rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rr grant %0d", i), req_ready, exp_rr[i]);
            chk($sformatf("fixed grant %0d", i), f_req_ready, 2'b01);
            tick();
            tick();
            chk($sformatf("rr rsp_valid %0d", i), rsp_valid, exp_rr[i]);
            chk($sformatf("rr rsp_tag %0d", i), rsp_tag, exp_rr[i] == 2'b10 ? 2'd2 : 2'd1);
            chk($sformatf("fixed rsp_data %0d", i), f_rsp_data, 16'h0002);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();

        // Back-pressure in RESP while port 1 waits.
        set_req(0, 2'b00, 16'h0100, 16'h0200, 2'd1);
        tick();
        req_valid = 2'b00;
        tick();
        set_req(1, 2'b01, 16'h0005, 16'h0003, 2'd2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold rsp_valid %0d", i), rsp_valid, 2'b01);
            chk($sformatf("hold rsp_data %0d", i), rsp_data, 16'h0300);
            chk($sformatf("hold rsp_tag %0d", i), rsp_tag, 2'd1);
            chk($sformatf("hold req_ready %0d", i), req_ready, 2'b00);
            tick();
        end
        rsp_ready = 2'b10;
        tick();
        chk("hold other-port ready ignored", rsp_valid, 2'b01);
        rsp_ready = 2'b01;
        tick();
        chk("hold waiter granted", req_ready, 2'b10);
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b00;
        chk("hold waiter add_b", add_b, 16'hFFFC);
        tick();
        chk("hold waiter rsp_valid", rsp_valid, 2'b10);
        chk("hold waiter rsp_data", rsp_data, 16'h0002);
        tick();
        rsp_ready = 2'b00;

        // Reset during EXEC drops the op and restores the round-robin pointer.
        set_req(1, 2'b00, 16'h0001, 16'h0001, 2'd3);
        tick();
        req_valid = 2'b00;
        chk("mid-op add_a before reset", add_a, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("mid-op reset add_bus", {add_a, add_b, add_sub, add_sat, add_red}, 35'h0);
        chk("mid-op reset rsp_valid", rsp_valid, 2'b00);
        tick();
        chk("mid-op reset rsp_data", rsp_data, 16'h0);
        chk("mid-op reset rsp_tag", rsp_tag, 2'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post-reset rsp_valid %0d", i), rsp_valid, 2'b00);
            tick();
        end
        set_req(0, 2'b00, 16'h0001, 16'h0001, 2'd1);
        set_req(1, 2'b00, 16'h0001, 16'h0001, 2'd2);
        #1;
        chk("post-reset rr pointer", req_ready, 2'b10);
        req_valid = 2'b00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
